// File: rtl/dram_timing_ctrl.sv
// dram_timing_ctrl: times the DRAM command intervals for the command FSM and tracks postponed refreshes
module dram_timing_ctrl #(
    parameter int T_INIT   = 200,
    parameter int T_RCD    = 14,
    parameter int T_RP     = 14,
    parameter int T_CL     = 16,
    parameter int T_CWL    = 12,
    parameter int T_BURST  = 4,
    parameter int T_WR     = 16,
    parameter int T_RFC    = 260,
    parameter int T_REFI   = 7800,
    parameter int MAX_PEND = 8
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [4:0] cmd_state,
    input  logic       init_req,
    output logic       init_done,
    output logic       tACT_done,
    output logic       tPRE_done,
    output logic       tRD_done,
    output logic       tWR_done,
    output logic       tREF_done,
    output logic       rf_req,
    output logic [3:0] pend_cnt,
    output logic       timing_err
);
    localparam logic [4:0] S_ACTIVATE = 5'd2, S_ACTIVATING = 5'd3, S_READ = 5'd4, S_READING = 5'd5,
                           S_WRITE = 5'd6, S_WRITING = 5'd7, S_PRECHARGE = 5'd8, S_PRECHARGING = 5'd9,
                           S_PRECHARGE_RE = 5'd10, S_PRECHARGING_RE = 5'd11, S_REFRESH = 5'd12,
                           S_REFRESHING = 5'd13;
    localparam int P_RD = T_CL + T_BURST;
    localparam int P_WR = T_CWL + T_BURST + T_WR;
    localparam int MX1  = T_RCD > P_RD ? T_RCD : P_RD;
    localparam int MX2  = MX1 > P_WR ? MX1 : P_WR;
    localparam int MX3  = MX2 > T_RP ? MX2 : T_RP;
    localparam int MAXT = MX3 > T_RFC ? MX3 : T_RFC;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int IW   = $clog2(T_INIT + 1);
    localparam int RW   = $clog2(T_REFI + 1);

    typedef enum logic [2:0] {C_NONE, C_ACT, C_RD, C_WR, C_PRE, C_REF} cls_e;

    logic [CW-1:0] cnt_q, cnt_d, load;
    cls_e          cls_q, cls_d, load_cls;
    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [RW-1:0] refi_q, refi_d;
    logic [3:0]    pend_q, pend_d;
    logic [4:0]    prev_st_q, prev_st_d;
    logic          init_done_q, init_done_d, ref_run_q, ref_run_d, rf_q, rf_d, err_q, err_d;
    logic          prev_bad_q, prev_bad_d;
    logic          issue, near, is_wait, own_done, wrap, do_ref, sat, starve;

    always_comb begin
        load     = '0;
        load_cls = C_NONE;
        case (cmd_state)
            S_ACTIVATE:                  begin load = CW'(T_RCD); load_cls = C_ACT; end
            S_READ:                      begin load = CW'(P_RD);  load_cls = C_RD;  end
            S_WRITE:                     begin load = CW'(P_WR);  load_cls = C_WR;  end
            S_PRECHARGE, S_PRECHARGE_RE: begin load = CW'(T_RP);  load_cls = C_PRE; end
            S_REFRESH:                   begin load = CW'(T_RFC); load_cls = C_REF; end
            default:                     ;
        endcase
        issue = load_cls != C_NONE;
        cnt_d = issue ? load : (cnt_q == '0 ? '0 : cnt_q - CW'(1));
        cls_d = issue ? load_cls : cls_q;
        // counter holds T in the cycle after issue, so value 2 marks cycle N+T-1
        near      = cnt_q <= CW'(2);
        tACT_done = near && cls_q == C_ACT && cmd_state == S_ACTIVATING;
        tRD_done  = near && cls_q == C_RD && cmd_state == S_READING;
        tWR_done  = near && cls_q == C_WR && cmd_state == S_WRITING;
        tPRE_done = near && cls_q == C_PRE && (cmd_state == S_PRECHARGING || cmd_state == S_PRECHARGING_RE);
        tREF_done = near && cls_q == C_REF && cmd_state == S_REFRESHING;
        is_wait   = cmd_state inside {S_ACTIVATING, S_READING, S_WRITING, S_PRECHARGING, S_PRECHARGING_RE, S_REFRESHING};
        own_done  = tACT_done | tRD_done | tWR_done | tPRE_done | tREF_done;
        init_cnt_d  = (init_req && !init_done_q) ? init_cnt_q + IW'(1) : '0;
        init_done_d = init_done_q | (init_req && init_cnt_q == IW'(T_INIT - 2));
        ref_run_d = init_done_q;
        wrap      = ref_run_q && refi_q == RW'(T_REFI - 1);
        refi_d    = (ref_run_q && !wrap) ? refi_q + RW'(1) : '0;
        do_ref    = cmd_state == S_REFRESH;
        sat       = wrap && !do_ref && pend_q == 4'(MAX_PEND);
        starve    = do_ref && !wrap && pend_q == '0;
        pend_d    = (wrap && !do_ref && !sat) ? pend_q + 4'd1 : (do_ref && !wrap && !starve) ? pend_q - 4'd1 : pend_q;
        rf_d      = pend_d != '0;
        err_d     = err_q | sat | starve | (prev_bad_q && cmd_state != prev_st_q);
        prev_bad_d = is_wait && !own_done;
        prev_st_d  = cmd_state;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q       <= '0;
            cls_q       <= C_NONE;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            ref_run_q   <= 1'b0;
            refi_q      <= '0;
            pend_q      <= '0;
            rf_q        <= 1'b0;
            err_q       <= 1'b0;
            prev_bad_q  <= 1'b0;
            prev_st_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            cls_q       <= cls_d;
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            ref_run_q   <= ref_run_d;
            refi_q      <= refi_d;
            pend_q      <= pend_d;
            rf_q        <= rf_d;
            err_q       <= err_d;
            prev_bad_q  <= prev_bad_d;
            prev_st_q   <= prev_st_d;
        end
    end

    assign init_done  = init_done_q;
    assign pend_cnt   = pend_q;
    assign rf_req     = rf_q;
    assign timing_err = err_q;
endmodule

// File: tb/tb_dram_timing_ctrl.sv
// tb_dram_timing_ctrl: cycle-numbered reference model plus directed and random command streams
module tb_dram_timing_ctrl;
    localparam int T_INIT = 5, T_RCD = 3, T_RP = 3, T_CL = 4, T_CWL = 3, T_BURST = 2, T_WR = 2;
    localparam int T_RFC = 5, T_REFI = 10, MAX_PEND = 8;
    localparam logic [4:0] PWR = 0, IDLE = 1, ACT = 2, ACTG = 3, RD = 4, RDG = 5, WR = 6, WRG = 7,
                           PRE = 8, PREG = 9, PRERE = 10, PRERG = 11, REF = 12, REFG = 13;

    logic       CLK = 1'b0, nRST = 1'b1, init_req = 1'b0;
    logic [4:0] cmd_state = PWR;
    logic       init_done, tACT_done, tPRE_done, tRD_done, tWR_done, tREF_done, rf_req, timing_err;
    logic [3:0] pend_cnt;
    int total = 0, bad = 0, cyc = 0;

    int m_is, m_idc, m_li, m_lp, m_pend, c;
    logic [4:0] m_lc, m_pcmd, own;
    logic m_err, m_pbad, ok_t, wrap_e, rf_e;

    dram_timing_ctrl #(.T_INIT(T_INIT), .T_RCD(T_RCD), .T_RP(T_RP), .T_CL(T_CL), .T_CWL(T_CWL),
        .T_BURST(T_BURST), .T_WR(T_WR), .T_RFC(T_RFC), .T_REFI(T_REFI), .MAX_PEND(MAX_PEND)) dut (
        .CLK(CLK), .nRST(nRST), .cmd_state(cmd_state), .init_req(init_req), .init_done(init_done),
        .tACT_done(tACT_done), .tPRE_done(tPRE_done), .tRD_done(tRD_done), .tWR_done(tWR_done),
        .tREF_done(tREF_done), .rf_req(rf_req), .pend_cnt(pend_cnt), .timing_err(timing_err));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    function automatic int period(input logic [4:0] s);
        case (s)
            ACT:        return T_RCD;
            RD:         return T_CL + T_BURST;
            WR:         return T_CWL + T_BURST + T_WR;
            PRE, PRERE: return T_RP;
            REF:        return T_RFC;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [4:0] owner(input logic [4:0] s);
        case (s)
            ACTG:        return ACT;
            RDG:         return RD;
            WRG:         return WR;
            PREG, PRERG: return PRE;
            REFG:        return REF;
            default:     return PWR;
        endcase
    endfunction

    function automatic logic [4:0] wait_of(input logic [4:0] s);
        case (s)
            ACT:     return ACTG;
            RD:      return RDG;
            WR:      return WRG;
            PRE:     return PREG;
            PRERE:   return PRERG;
            default: return REFG;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (!nRST) begin
            chk("rst_init_done", init_done, 0);
            chk("rst_dones", {tACT_done, tPRE_done, tRD_done, tWR_done, tREF_done}, 0);
            chk("rst_rf_req", rf_req, 0);
            chk("rst_pend", pend_cnt, 0);
            chk("rst_err", timing_err, 0);
            m_is = -1; m_idc = -1; m_li = 0; m_lp = 0; m_lc = PWR;
            m_pend = 0; m_err = 0; m_pbad = 0; m_pcmd = PWR;
        end else begin
            c    = cyc;
            own  = owner(cmd_state);
            ok_t = m_lc != PWR && own == m_lc && c >= m_li + m_lp - 1;
            chk("init_done", init_done, int'(m_idc >= 0 && c >= m_idc));
            chk("tACT_done", tACT_done, int'(ok_t && own == ACT));
            chk("tRD_done", tRD_done, int'(ok_t && own == RD));
            chk("tWR_done", tWR_done, int'(ok_t && own == WR));
            chk("tPRE_done", tPRE_done, int'(ok_t && own == PRE));
            chk("tREF_done", tREF_done, int'(ok_t && own == REF));
            chk("pend_cnt", pend_cnt, m_pend);
            chk("rf_req", rf_req, int'(m_pend != 0));
            chk("timing_err", timing_err, int'(m_err));
            if (m_idc < 0) begin
                if (init_req) begin
                    if (m_is < 0) m_is = c;
                    if (c - m_is == T_INIT - 2) m_idc = c + 1;
                end else m_is = -1;
            end
            wrap_e = m_idc >= 0 && c > m_idc && (c - m_idc) % T_REFI == 0;
            rf_e   = cmd_state == REF;
            if (wrap_e && !rf_e) begin
                if (m_pend == MAX_PEND) m_err = 1; else m_pend++;
            end
            if (rf_e && !wrap_e) begin
                if (m_pend == 0) m_err = 1; else m_pend--;
            end
            if (m_pbad && cmd_state != m_pcmd) m_err = 1;
            m_pbad = own != PWR && !ok_t;
            m_pcmd = cmd_state;
            if (period(cmd_state) > 0) begin
                m_li = c;
                m_lp = period(cmd_state);
                m_lc = cmd_state == PRERE ? PRE : cmd_state;
            end
        end
    end

    task automatic drive(input logic [4:0] s, input logic ir);
        @(posedge CLK); #1;
        cmd_state = s;
        init_req  = ir;
    endtask

    task automatic to(input int t, input logic [4:0] s);
        while (cyc < t) drive(s, 1'b0);
    endtask

    task automatic reset_init(output int d);
        @(posedge CLK); #1;
        nRST = 1'b0; cmd_state = PWR; init_req = 1'b0;
        @(negedge CLK);
        chk("lit_rst_init", init_done, 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(PWR, 1'b1);
            @(negedge CLK);
            if (k == 3) chk("lit_init_early", init_done, 0);
            if (k == 4) chk("lit_init_rise", init_done, 1);
        end
        d = cyc;
    endtask

    initial begin
        int d, n;
        reset_init(d);
        drive(IDLE, 1'b0); @(negedge CLK); chk("lit_init_hold", init_done, 1);
        to(d + 10, IDLE); @(negedge CLK); chk("lit_pend_pre_wrap", pend_cnt, 0);
        to(d + 11, IDLE); @(negedge CLK); chk("lit_pend_1", pend_cnt, 1); chk("lit_rf_req_1", rf_req, 1);
        to(d + 31, IDLE); @(negedge CLK); chk("lit_pend_3", pend_cnt, 3);
        to(d + 39, IDLE); drive(REF, 1'b0);
        drive(REFG, 1'b0); @(negedge CLK); chk("lit_pend_wrap_ref", pend_cnt, 3);
        to(d + 43, REFG); @(negedge CLK); chk("lit_tref_early", tREF_done, 0);
        drive(REFG, 1'b0); @(negedge CLK); chk("lit_tref", tREF_done, 1);
        drive(ACT, 1'b0); n = cyc;
        drive(ACTG, 1'b0); @(negedge CLK); chk("lit_tact_early", tACT_done, 0);
        drive(ACTG, 1'b0); @(negedge CLK); chk("lit_tact", tACT_done, 1);
        drive(RD, 1'b0); @(negedge CLK); chk("lit_tact_off", tACT_done, 0);
        to(n + 7, RDG); @(negedge CLK); chk("lit_trd_early", tRD_done, 0);
        drive(RDG, 1'b0); @(negedge CLK); chk("lit_trd", tRD_done, 1);
        drive(WR, 1'b0);
        to(n + 14, WRG); @(negedge CLK); chk("lit_twr_early", tWR_done, 0);
        drive(WRG, 1'b0); @(negedge CLK); chk("lit_twr", tWR_done, 1);
        drive(ACT, 1'b0); drive(PRERE, 1'b0);
        to(n + 18, PRERG); @(negedge CLK); chk("lit_tpre_early", tPRE_done, 0);
        drive(PRERG, 1'b0); @(negedge CLK); chk("lit_tpre", tPRE_done, 1); chk("lit_no_err", timing_err, 0);
        to(d + 91, IDLE); @(negedge CLK); chk("lit_pend_max", pend_cnt, 8); chk("lit_err_before_sat", timing_err, 0);
        to(d + 101, IDLE); @(negedge CLK); chk("lit_pend_sat", pend_cnt, 8); chk("lit_err_sat", timing_err, 1);

        reset_init(d);
        drive(ACT, 1'b0); drive(ACTG, 1'b0); drive(ACTG, 1'b0);
        drive(RD, 1'b0); drive(RDG, 1'b0); drive(RDG, 1'b0);
        @(posedge CLK); #3; nRST = 1'b0; #1;
        chk("lit_async_init", init_done, 0);
        chk("lit_async_pend", pend_cnt, 0);
        chk("lit_async_trd", tRD_done, 0);
        reset_init(d);
        drive(PRE, 1'b0); drive(PREG, 1'b0); drive(IDLE, 1'b0);
        @(negedge CLK); chk("lit_err_not_yet", timing_err, 0);
        drive(IDLE, 1'b0); @(negedge CLK); chk("lit_err_early_exit", timing_err, 1);

        reset_init(d);
        drive(REF, 1'b0); @(negedge CLK); chk("lit_err_ref0_pre", timing_err, 0);
        drive(IDLE, 1'b0); @(negedge CLK); chk("lit_err_ref0", timing_err, 1);

        reset_init(d);
        for (int it = 0; it < 400; it++) begin
            logic [4:0] s;
            int per, w;
            if (it % 80 == 79) reset_init(d);
            if (m_pend > 0 && $urandom_range(0, 9) < 4) s = REF;
            else case ($urandom_range(0, 5))
                0: s = ACT;
                1: s = RD;
                2: s = WR;
                3: s = PRE;
                4: s = PRERE;
                default: s = REF;
            endcase
            per = period(s);
            w = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, per - 2)) : per - 1 + int'($urandom_range(0, 3));
            drive(s, 1'b0);
            repeat (w) drive(wait_of(s), 1'b0);
            repeat ($urandom_range(0, 2)) drive(IDLE, 1'b0);
        end
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
